// File: rtl/mul8x8_seq_ctrl.sv
// Unsigned 8x8 -> 16-bit multiplier that reuses one combinational 4x4 array
// core over four cycles, with valid/ready handshakes on operands and result.

module mul4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    // NOTE: combinational logic uses blocking assignments and assigns a default first, so no latch is inferred.
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                p = p + (8'(x) << i);
            end
        end
    end
endmodule

module mul8x8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;

    logic [3:0]  core_x;
    logic [3:0]  core_y;
    logic [7:0]  core_p;
    logic [15:0] pp_shifted;

    // step[0] selects the high nibble of a, step[1] the high nibble of b.
    assign core_x = step[0] ? a_r[7:4] : a_r[3:0];
    assign core_y = step[1] ? b_r[7:4] : b_r[3:0];

    mul4x4 u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    always_comb begin
        pp_shifted = '0;
        case (step)
            2'd0:    pp_shifted = {8'h00, core_p};
            2'd1,
            2'd2:    pp_shifted = {4'h0, core_p, 4'h0};
            default: pp_shifted = {core_p, 8'h00};
        endcase
    end

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);
    assign product  = acc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            acc       <= 16'h0000;
            out_valid <= 1'b0;
        end else if (abort) begin
            // Cancel wins over acceptance; an idle abort leaves the last result intact.
            if (state != IDLE) begin
                acc <= 16'h0000;
            end
            state     <= IDLE;
            step      <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= 16'h0000;
                        step  <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step      <= 2'd0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Scoreboard bench for mul8x8_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops them on each result handshake and checks latency.

module tb_mul8x8_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   failures;
    logic ov_prev;

    mul8x8_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs are driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input bit push,
                         input logic [15:0] exp_prod, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        acc_cyc  = cyc + 1;
        if (push) q.push_back('{prod: exp_prod, acc_cyc: acc_cyc});
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: latency on the out_valid rising edge, product on each handshake.
    initial ov_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (q.size() == 0) check("out_valid_without_pending", out_valid, 0);
                else check("latency", cyc - q[0].acc_cyc, 4);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("handshake_without_pending", out_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("product", product, e.prod);
                end
            end
        end
        ov_prev = rst_n ? out_valid : 1'b0;
    end

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    initial begin
        vec_t corners[4];
        int   acc_cyc;
        int   prev_cyc;
        int   n;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        abort     = 1'b0;
        out_ready = 1'b1;

        corners[0] = '{x: 8'hFF, y: 8'hFF, p: 16'hFE01};
        corners[1] = '{x: 8'h00, y: 8'hAB, p: 16'h0000};
        corners[2] = '{x: 8'hA5, y: 8'h5A, p: 16'h3A02};
        corners[3] = '{x: 8'h0F, y: 8'hF0, p: 16'h0E10};

        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Basic transaction.
        issue(8'h12, 8'h34, 1'b1, 16'h03A8, acc_cyc);
        check("accept_in_ready_drop", in_ready, 0);
        check("accept_busy", busy, 1);
        repeat (5) tick();
        check("basic_back_to_idle", in_ready, 1);
        check("basic_out_valid_low", out_valid, 0);

        // Corners back to back with out_ready held high.
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            issue(corners[i].x, corners[i].y, 1'b1, corners[i].p, acc_cyc);
            if (i > 0) check("issue_interval", acc_cyc - prev_cyc, 6);
            prev_cyc = acc_cyc;
        end
        repeat (6) tick();

        // Backpressure with operand toggling during the wait.
        out_ready = 1'b0;
        issue(8'h80, 8'h02, 1'b1, 16'h0100, acc_cyc);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, 16'h0100);
            check("bp_in_ready", in_ready, 0);
            a = ~a;
            b = b + 8'h37;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_product_retained", product, 16'h0100);
        out_ready = 1'b1;

        // Abort while step2 is active.
        issue(8'h33, 8'h44, 1'b0, 16'h0000, acc_cyc);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_acc_cleared", product, 16'h0000);
        issue(8'h02, 8'h03, 1'b1, 16'h0006, acc_cyc);
        repeat (6) tick();

        // Abort and in_valid together in IDLE.
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_in_ready", in_ready, 1);
        tick();
        check("idle_abort_busy_later", busy, 0);

        // Asynchronous reset mid-MUL.
        issue(8'h55, 8'h66, 1'b0, 16'h0000, acc_cyc);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_product", product, 16'h0000);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_in_ready", in_ready, 1);
        issue(8'h07, 8'h09, 1'b1, 16'h003F, acc_cyc);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("scoreboard_drained", q.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
